// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_pkg : shared parity modes, receiver states and status-field indices   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PAR       = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  // Status bits sit directly above the payload in each FIFO word.
  localparam int PERR   = 0;
  localparam int FERR   = 1;
  localparam int BRK    = 2;
  localparam int STAT_W = 3;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo : show-ahead single-clock FIFO; a write while full is accepted  |
// | only when a read happens in the same cycle.           Revision : 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +----------------------------------------------------------------------------+
// | uart_rx_fifo : UART receiver with 3-sample majority vote, per-word status |
// | and a valid/ready output FIFO with sticky overrun.    Revision : 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 m_break,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = 4;
  localparam int WORD_W = DATA_BITS + STAT_W;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(CLKS_PER_BIT - 3);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_END = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_END = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY == PARITY_ODD);

  logic                 sync1_q;
  logic                 rxs_q;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q;

  logic                 bit_now;
  logic                 bit_last;
  logic                 ferr_now;
  logic                 brk_now;
  logic                 push;
  logic [WORD_W-1:0]    push_word;
  logic [WORD_W-1:0]    fifo_rd_data;
  logic [WORD_W-1:0]    head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  // Third vote comes straight from rxs on the decision cycle.
  assign bit_now   = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign bit_last  = (cnt_q == CNT_LAST);
  assign ferr_now  = ferr_q | ~bit_now;
  assign brk_now   = ferr_now && (data_q == '0);
  assign push_word = {brk_now, ferr_now, perr_q, data_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;

    if (state_q == ST_DATA || state_q == ST_PAR || state_q == ST_STOP) begin
      if (cnt_q == CNT_S0) s0_d = rxs_q;
      if (cnt_q == CNT_S1) s1_d = rxs_q;
      if (bit_last) cnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!rxs_q) begin
          state_d = ST_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_last) begin
          data_d = {bit_now, data_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_END) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (bit_last) begin
          perr_d  = (bit_now != ((^data_q) ^ PAR_ODD));
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_last) begin
          ferr_d = ferr_now;
          if (bit_cnt_q == STOP_END) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            state_d   = ferr_now ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pop = !fifo_empty && m_ready;

  // A drop only happens when no pop frees a slot in the same cycle; set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (push && fifo_full && !pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= rx;
      rxs_q     <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (m_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head         = fifo_empty ? '0 : fifo_rd_data;
  assign m_valid      = !fifo_empty;
  assign m_data       = head[DATA_BITS-1:0];
  assign m_parity_err = head[DATA_BITS + PERR];
  assign m_frame_err  = head[DATA_BITS + FERR];
  assign m_break      = head[DATA_BITS + BRK];
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_uart_rx_fifo : randomized frames on three receiver configurations,     |
// | scored against a frame-level model.                   Revision : 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic rx0 = 1'b1, rdy0 = 1'b1, clr0 = 1'b0;
  logic rx1 = 1'b1, rdy1 = 1'b1, clr1 = 1'b0;
  logic rx2 = 1'b1, rdy2 = 1'b1, clr2 = 1'b0;

  logic       v0, pe0, fe0, brk0, ov0, busy0;
  logic [7:0] d0;
  logic       v1, pe1, fe1, brk1, ov1, busy1;
  logic [7:0] d1;
  logic       v2, pe2, fe2, brk2, ov2, busy2;
  logic [4:0] d2;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  logic [11:0] exp_q2[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .m_valid(v0), .m_ready(rdy0), .m_data(d0),
    .m_parity_err(pe0), .m_frame_err(fe0), .m_break(brk0), .overrun(ov0),
    .overrun_clr(clr0), .busy(busy0));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .m_valid(v1), .m_ready(rdy1), .m_data(d1),
    .m_parity_err(pe1), .m_frame_err(fe1), .m_break(brk1), .overrun(ov1),
    .overrun_clr(clr1), .busy(busy1));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .m_valid(v2), .m_ready(rdy2), .m_data(d2),
    .m_parity_err(pe2), .m_frame_err(fe2), .m_break(brk2), .overrun(ov2),
    .overrun_clr(clr2), .busy(busy2));

  function automatic int nb(input int i);
    return (i == 2) ? 5 : 8;
  endfunction

  function automatic int par(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic int sb(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] mask_data(input int i, input logic [8:0] d);
    logic [8:0] m;
    m = 9'((1 << nb(i)) - 1);
    return d & m;
  endfunction

  // Parity bit a correct transmitter would send.
  function automatic logic good_par(input int i, input logic [8:0] d);
    return (^mask_data(i, d)) ^ (par(i) == 1);
  endfunction

  function automatic logic [11:0] exp_word(input int i, input logic [8:0] d,
                                           input logic pb, input logic [1:0] sv);
    logic [8:0] dm;
    logic       pe, fe, bk;
    dm = mask_data(i, d);
    pe = (par(i) != 0) && (pb != good_par(i, d));
    fe = !sv[0] || (sb(i) == 2 && !sv[1]);
    bk = fe && (dm == 9'd0);
    return {bk, fe, pe, dm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_rx(input int i, input logic v);
    case (i)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic push_exp(input int i, input logic [11:0] w);
    case (i)
      0:       exp_q0.push_back(w);
      1:       exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endtask

  task automatic mon_pop(input int i, input logic [11:0] obs);
    logic [11:0] e;
    int          sz;
    case (i)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    if (sz == 0) begin
      check($sformatf("u%0d_unexpected_word", i), 32'(obs), 32'hFFFF_FFFF);
    end else begin
      case (i)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      check($sformatf("u%0d_word", i), 32'(obs), 32'(e));
    end
  endtask

  always @(negedge clk) if (rst_n && v0 && rdy0) mon_pop(0, {brk0, fe0, pe0, 1'b0, d0});
  always @(negedge clk) if (rst_n && v1 && rdy1) mon_pop(1, {brk1, fe1, pe1, 1'b0, d1});
  always @(negedge clk) if (rst_n && v2 && rdy2) mon_pop(2, {brk2, fe2, pe2, 4'b0, d2});

  // One bit period; sp selects a single inverted cycle (-1 for none).
  task automatic drive_bit(input int i, input logic v, input int sp);
    for (int c = 0; c < CPB; c++) begin
      @(posedge clk);
      #1;
      set_rx(i, (c == sp) ? ~v : v);
    end
  endtask

  task automatic idle_bits(input int i, input int n);
    for (int k = 0; k < n; k++) drive_bit(i, 1'b1, -1);
  endtask

  task automatic send_frame(input int i, input logic [8:0] d, input logic pb,
                            input logic [1:0] sv, input bit spikes, input bit do_push);
    if (do_push) push_exp(i, exp_word(i, d, pb, sv));
    drive_bit(i, 1'b0, -1);
    for (int j = 0; j < nb(i); j++)
      drive_bit(i, d[j], spikes ? int'($urandom_range(0, CPB - 1)) : -1);
    if (par(i) != 0)
      drive_bit(i, pb, spikes ? int'($urandom_range(0, CPB - 1)) : -1);
    for (int k = 0; k < sb(i); k++) drive_bit(i, sv[k], -1);
  endtask

  task automatic rand_frames(input int i, input int n);
    logic [8:0] d;
    logic       pb;
    logic [1:0] sv;
    logic       fe;
    for (int k = 0; k < n; k++) begin
      d  = 9'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~good_par(i, d) : good_par(i, d);
      sv = {logic'($urandom_range(0, 4) != 0), logic'($urandom_range(0, 4) != 0)};
      fe = !sv[0] || (sb(i) == 2 && !sv[1]);
      send_frame(i, d, pb, sv, bit'($urandom_range(0, 1)), 1'b1);
      idle_bits(i, fe ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_u0_outputs", {v0, pe0, fe0, brk0, ov0, busy0, d0}, 0);
    check("reset_u2_outputs", {v2, pe2, fe2, brk2, ov2, busy2, d2}, 0);
    rst_n = 1'b1;
    idle_bits(0, 1);

    // 8N1 back-to-back
    send_frame(0, 9'hA5, 1'b0, 2'b11, 1'b0, 1'b1);
    send_frame(0, 9'h3C, 1'b0, 2'b11, 1'b0, 1'b1);
    idle_bits(0, 2);
    check("u0_b2b_drained", exp_q0.size(), 0);

    // even parity: correct then wrong parity bit
    send_frame(1, 9'h07, 1'b1, 2'b11, 1'b0, 1'b1);
    send_frame(1, 9'h07, 1'b0, 2'b11, 1'b0, 1'b1);
    idle_bits(1, 2);
    check("u1_parity_drained", exp_q1.size(), 0);
    rand_frames(1, 10);
    idle_bits(1, 3);
    check("u1_rand_drained", exp_q1.size(), 0);

    // 5 data bits, odd parity, 2 stop bits
    send_frame(2, 9'h1F, good_par(2, 9'h1F), 2'b11, 1'b0, 1'b1);
    send_frame(2, 9'h0A, good_par(2, 9'h0A), 2'b11, 1'b0, 1'b1);
    send_frame(2, 9'h00, good_par(2, 9'h00), 2'b10, 1'b0, 1'b1);
    idle_bits(2, 2);
    rand_frames(2, 10);
    idle_bits(2, 3);
    check("u2_drained", exp_q2.size(), 0);

    rand_frames(0, 15);
    idle_bits(0, 3);
    check("u0_rand_drained", exp_q0.size(), 0);

    // line held low for 12 bit times
    push_exp(0, 12'hC00);
    for (int k = 0; k < 12; k++) drive_bit(0, 1'b0, -1);
    check("break_busy_held", busy0, 1);
    idle_bits(0, 2);
    check("break_busy_released", busy0, 0);
    check("break_one_word", exp_q0.size(), 0);

    // 8-cycle glitch on idle line
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 rx0 = 1'b0;
    end
    @(posedge clk);
    #1 rx0 = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_busy", busy0, 1);
    idle_bits(0, 2);
    check("glitch_idle", busy0, 0);
    check("glitch_no_push", v0, 0);
    send_frame(0, 9'h55, 1'b0, 2'b11, 1'b1, 1'b1);
    idle_bits(0, 2);
    check("spike_drained", exp_q0.size(), 0);

    // fill FIFO with consumer stalled
    @(posedge clk);
    #1 rdy0 = 1'b0;
    for (int k = 0; k < 4; k++) send_frame(0, 9'($urandom), 1'b0, 2'b11, 1'b0, 1'b1);
    idle_bits(0, 1);
    check("full_no_overrun", ov0, 0);
    check("full_valid", v0, 1);
    send_frame(0, 9'h5A, 1'b0, 2'b11, 1'b0, 1'b0);
    idle_bits(0, 1);
    check("overrun_set", ov0, 1);
    @(posedge clk);
    #1 clr0 = 1'b1;
    @(posedge clk);
    #1 clr0 = 1'b0;
    check("overrun_cleared", ov0, 0);
    rdy0 = 1'b1;
    idle_bits(0, 1);
    check("fifo_order_drained", exp_q0.size(), 0);

    // reset in the middle of a frame with a word held
    rdy0 = 1'b0;
    send_frame(0, 9'h3E, 1'b0, 2'b11, 1'b0, 1'b1);
    idle_bits(0, 1);
    drive_bit(0, 1'b0, -1);
    for (int j = 0; j < 3; j++) drive_bit(0, 1'b1, -1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("rst_mid_valid", v0, 0);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_data", {pe0, fe0, brk0, ov0, d0}, 0);
    exp_q0.delete();
    rx0 = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy0 = 1'b1;
    idle_bits(0, 2);
    check("post_rst_empty", v0, 0);
    send_frame(0, 9'h81, 1'b0, 2'b11, 1'b0, 1'b1);
    idle_bits(0, 2);
    check("post_rst_drained", exp_q0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
